// File: rtl/avb_bram_reader.sv
// Avalon-MM master that drains a block of words from a pointer/data-window BRAM slave
// and presents them on a valid/ready stream through a first-word-fall-through FIFO.
module avb_bram_reader #(
  parameter logic [31:0] SLAVE_BASE = 32'h0,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 cmd_start,
  input  logic [31:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 cmd_busy,
  output logic                 cmd_done,
  output logic [31:0]          avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  output logic [3:0]           avm_byteenable,
  input  logic                 avm_waitrequest,
  input  logic [31:0]          avm_readdata,
  input  logic                 avm_readdatavalid,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [2:0] {S_IDLE, S_WR_PTR, S_RD_ISSUE, S_WAIT_RSP, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          avm_address_q, avm_address_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] popped_q, popped_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          mem [FIFO_DEPTH];
  logic                 accept, push, pop;
  logic [CW:0]          inflight_d;

  assign accept = read_q & ~avm_waitrequest;
  assign push   = avm_readdatavalid & (outst_q != '0);
  assign pop    = (count_q != '0) & out_ready;

  always_comb begin
    count_d  = count_q;
    outst_d  = outst_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({accept, push})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    // Credit is judged on next-cycle occupancy so a newly raised read is always covered.
    inflight_d = {1'b0, count_d} + {1'b0, outst_d};
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    popped_d      = pop ? popped_q + LEN_WIDTH'(1) : popped_q;
    read_d        = read_q;
    write_d       = write_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    avm_address_d = avm_address_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          issued_d = '0;
          popped_d = '0;
          busy_d   = 1'b1;
          if (cmd_len == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d       = S_WR_PTR;
            write_d       = 1'b1;
            avm_address_d = SLAVE_BASE;
          end
        end
      end
      S_WR_PTR: begin
        if (!avm_waitrequest) begin
          state_d       = S_RD_ISSUE;
          write_d       = 1'b0;
          read_d        = 1'b1;
          avm_address_d = SLAVE_BASE + 32'd4;
        end
      end
      S_RD_ISSUE: begin
        if (accept) issued_d = issued_q + LEN_WIDTH'(1);
        if (issued_d == len_q) begin
          state_d = S_WAIT_RSP;
          read_d  = 1'b0;
        end else if (read_q && avm_waitrequest) begin
          read_d = 1'b1;
        end else begin
          read_d = inflight_d < DEPTH_C;
        end
      end
      S_WAIT_RSP: begin
        if (popped_d == len_q) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      count_q       <= '0;
      outst_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      avm_address_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      popped_q      <= popped_d;
      count_q       <= count_d;
      outst_q       <= outst_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      read_q        <= read_d;
      write_q       <= write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      avm_address_q <= avm_address_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= avm_readdata;
  end

  assign avm_address    = avm_address_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = addr_q;
  assign avm_byteenable = 4'hF;
  assign cmd_busy       = busy_q;
  assign cmd_done       = done_q;
  assign out_valid      = count_q != '0;
  assign out_data       = out_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_avb_bram_reader.sv
// Bench for avb_bram_reader: pointer/window slave model, expected-word queue computed
// from start address and length, table of commands plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_avb_bram_reader;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cmd_start;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_busy, cmd_done;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  always #5 clock = ~clock;

  avb_bram_reader #(.SLAVE_BASE(32'h0), .LEN_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Slave/consumer knobs: ready_mode 0 = never, 1 = always, 2 = random.
  int unsigned wait_pct = 0;
  int unsigned max_lat = 1;
  int          ready_mode = 1;
  bit          inject_rdv = 1'b0;

  int unsigned n_wr, n_rd, n_pop, n_done, n_busy, max_inflight;
  int unsigned cyc = 0, last_pop_cyc = 0, last_due = 0, lat, due, inflight;
  logic [31:0] ptr = '0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;

  typedef struct { int unsigned due; logic [31:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned len;
    int unsigned wait_pct;
    int unsigned max_lat;
    int          ready_mode;
    int unsigned exp_writes;
    int unsigned exp_reads;
    int unsigned max_busy;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx * 32'h9E3779B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave, consumer and protocol monitor; everything happens on the falling edge.
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; out_ready = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        rsp_q.delete();
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        stall_prev = 1'b0; last_due = 0;
        continue;
      end
      avm_waitrequest = $urandom_range(99) < wait_pct;
      if (inject_rdv) begin
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; inject_rdv = 1'b0;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        avm_readdatavalid = 1'b1; avm_readdata = rsp_q[0].data; void'(rsp_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0; avm_readdata = $urandom;
      end
      out_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);

      if (avm_read || avm_write) check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (stall_prev) begin
        check("read_held", 32'(avm_read), 32'd1);
        check("addr_held", avm_address, stall_addr);
      end
      stall_prev = avm_read && avm_waitrequest;
      stall_addr = avm_address;
      if (avm_write && !avm_waitrequest) begin
        n_wr++;
        check("wr_addr", avm_address, 32'h0);
        ptr = avm_writedata;
      end
      if (avm_read && !avm_waitrequest) begin
        n_rd++;
        check("rd_addr", avm_address, 32'h4);
        lat = $urandom_range(max_lat, 1);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_q.push_back('{due, mem_word(ptr)});
        ptr++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("word", out_data, exp_q.pop_front());
        end
      end
      inflight = n_rd - n_pop;
      if (inflight > max_inflight) max_inflight = inflight;
      if (cmd_busy) n_busy++;
      if (cmd_done) begin
        n_done++;
        if (n_pop > 0) check("done_latency", cyc - last_pop_cyc, 32'd1);
      end
    end
  end

  task automatic clear_stats();
    n_wr = 0; n_rd = 0; n_pop = 0; n_done = 0; n_busy = 0; max_inflight = 0;
  endtask

  task automatic start_cmd(input logic [31:0] addr, input int unsigned len);
    clear_stats();
    for (int unsigned k = 0; k < len; k++) exp_q.push_back(mem_word(addr + k));
    @(negedge clock);
    cmd_start = 1'b1; cmd_addr = addr; cmd_len = 16'(len);
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned i = 0;
    while (n_done == 0 && i < budget) begin
      @(negedge clock);
      i++;
    end
    if (n_done == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no cmd_done expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic end_checks(input string name, input int unsigned len, input int unsigned exp_wr,
                            input int unsigned exp_rd, input int unsigned max_busy);
    repeat (4) @(negedge clock);
    check({name, "_done_count"}, n_done, 32'd1);
    check({name, "_words"}, n_pop, len);
    check({name, "_writes"}, n_wr, exp_wr);
    check({name, "_reads"}, n_rd, exp_rd);
    check({name, "_exp_left"}, exp_q.size(), 32'd0);
    check({name, "_inflight_le8"}, 32'(max_inflight <= 8), 32'd1);
    check({name, "_busy_idle"}, 32'(cmd_busy), 32'd0);
    if (max_busy > 0) check({name, "_throughput"}, 32'(n_busy <= max_busy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(cmd_busy), 32'd0);
    check({name, "_done"}, 32'(cmd_done), 32'd0);
    check({name, "_read"}, 32'(avm_read), 32'd0);
    check({name, "_write"}, 32'(avm_write), 32'd0);
    check({name, "_address"}, avm_address, 32'd0);
    check({name, "_writedata"}, avm_writedata, 32'd0);
    check({name, "_byteenable"}, 32'(avm_byteenable), 32'hF);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_data"}, out_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    vecs[0] = '{32'h10, 4, 0, 1, 1, 1, 4, 10};
    vecs[1] = '{32'h0, 1, 0, 1, 1, 1, 1, 7};
    vecs[2] = '{$urandom, 64, 0, 1, 1, 1, 64, 70};
    vecs[3] = '{$urandom, 100, 50, 4, 1, 1, 100, 0};
    vecs[4] = '{$urandom, 37, 30, 3, 2, 1, 37, 0};
    vecs[5] = '{32'hFFFF_FFFE, 5, 0, 2, 2, 1, 5, 0};
    for (int v = 0; v < 6; v++) begin
      wait_pct = vecs[v].wait_pct; max_lat = vecs[v].max_lat; ready_mode = vecs[v].ready_mode;
      start_cmd(vecs[v].addr, vecs[v].len);
      wait_done($sformatf("vec%0d", v), 20 * vecs[v].len + 50);
      end_checks($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_writes,
                 vecs[v].exp_reads, vecs[v].max_busy);
    end
    wait_pct = 0; max_lat = 1; ready_mode = 1;

    // Zero-length command: single-cycle busy and done, no bus traffic.
    start_cmd(32'h55, 0);
    check("len0_busy_c1", 32'(cmd_busy), 32'd1);
    check("len0_done_c1", 32'(cmd_done), 32'd1);
    @(negedge clock);
    check("len0_busy_c2", 32'(cmd_busy), 32'd0);
    check("len0_done_c2", 32'(cmd_done), 32'd0);
    end_checks("len0", 0, 0, 0, 0);

    // Consumer stalled: reads capped at FIFO depth until ready returns.
    ready_mode = 0;
    start_cmd(32'h100, 20);
    repeat (60) @(negedge clock);
    check("stall_reads", n_rd, 32'd8);
    check("stall_read_low", 32'(avm_read), 32'd0);
    check("stall_pops", n_pop, 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_busy", 32'(cmd_busy), 32'd1);
    ready_mode = 1;
    wait_done("stall", 400);
    end_checks("stall", 20, 1, 20, 0);

    // Reset during read issue, stray readdatavalid afterwards, then a fresh command.
    start_cmd(32'h200, 50);
    for (int i = 0; i < 100 && n_rd < 5; i++) @(negedge clock);
    check("abort_reached_reads", 32'(n_rd >= 5), 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
    inject_rdv = 1'b1;
    repeat (4) @(negedge clock);
    check("stray_rdv_valid", 32'(out_valid), 32'd0);
    start_cmd(32'h0, 2);
    wait_done("after_reset", 100);
    end_checks("after_reset", 2, 1, 2, 0);

    // Second start while busy must be ignored.
    ready_mode = 2;
    start_cmd(32'h40, 6);
    repeat (2) @(negedge clock);
    cmd_start = 1'b1; cmd_addr = 32'h80; cmd_len = 16'd3;
    @(negedge clock);
    cmd_start = 1'b0;
    wait_done("restart", 200);
    repeat (20) @(negedge clock);
    end_checks("restart", 6, 1, 6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
